// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//
// Purpose:
//   Shares a single unified memory port between the fetch stage (instruction
//   reads) and the memory stage (loads/stores). Only one bus transaction is
//   outstanding at a time, and its response is routed back to whichever
//   requester issued it. Data accesses win arbitration, but a streak counter
//   caps how many data grants in a row may pass a waiting fetch, so fetch
//   cannot be starved indefinitely.
//
// Parameters:
//   MaxDataStreak - consecutive data grants allowed while fetch waits (>= 1)
//   AddrWidth     - address width
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   fetchRequest/Address/Flush      - instruction read request, redirect cancel
//   fetchGrant, fetchResponseValid, fetchData - fetch handshake and returned word
//   dataRequest/Address/WriteEnable/WriteStrobe/WriteData - load/store request
//   dataGrant, dataResponseValid, dataReadData - data handshake and load data
//   memRequest/Address/WriteEnable/WriteStrobe/WriteData - bus request side
//   memReady            - bus accepts the presented request this cycle
//   memResponseValid, memReadData - bus response
// -----------------------------------------------------------------------------
module memory_arbiter #(
  parameter int MaxDataStreak = 4,
  parameter int AddrWidth     = 32
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 fetchRequest,
  input  logic [AddrWidth-1:0] fetchAddress,
  input  logic                 fetchFlush,
  output logic                 fetchGrant,
  output logic                 fetchResponseValid,
  output logic [31:0]          fetchData,

  input  logic                 dataRequest,
  input  logic [AddrWidth-1:0] dataAddress,
  input  logic                 dataWriteEnable,
  input  logic [3:0]           dataWriteStrobe,
  input  logic [31:0]          dataWriteData,
  output logic                 dataGrant,
  output logic                 dataResponseValid,
  output logic [31:0]          dataReadData,

  output logic                 memRequest,
  output logic [AddrWidth-1:0] memAddress,
  output logic                 memWriteEnable,
  output logic [3:0]           memWriteStrobe,
  output logic [31:0]          memWriteData,
  input  logic                 memReady,
  input  logic                 memResponseValid,
  input  logic [31:0]          memReadData
);

  localparam int StreakWidth = $clog2(MaxDataStreak + 1);
  localparam logic [StreakWidth-1:0] StreakLimit = StreakWidth'(MaxDataStreak);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } stateT;

  typedef enum logic {
    OwnerFetch,
    OwnerData
  } ownerT;

  stateT                 state;
  stateT                 nextState;
  ownerT                 owner;
  logic [AddrWidth-1:0]  latchedAddress;
  logic                  latchedWriteEnable;
  logic [3:0]            latchedStrobe;
  logic [31:0]           latchedWriteData;
  logic                  cancel;
  logic [StreakWidth-1:0] streak;

  logic                  fetchEligible;
  logic                  dataWins;
  logic                  fetchWins;
  logic                  fetchBusy;
  logic                  leavingBusy;

  // A flushing fetch is not a real request: it must neither win arbitration
  // nor count as "waiting" for the starvation bound. Data only yields once the
  // streak has reached the limit while fetch is actually waiting.
  assign fetchEligible = fetchRequest & ~fetchFlush;
  assign dataWins      = dataRequest & (~fetchEligible | (streak < StreakLimit));
  assign fetchWins     = fetchEligible & ~dataWins;

  // A fetch-owned transaction is on the bus or awaiting its reply.
  assign fetchBusy   = (state != StIdle) && (owner == OwnerFetch);
  assign leavingBusy = (state != StIdle) && (nextState == StIdle);

  // State register; reset abandons whatever transaction was in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= StIdle;
    end else begin
      state <= nextState;
    end
  end

  // Capture the winner's request at the grant edge so the requester is free
  // to change its inputs from the following cycle. Fetch never writes, so its
  // write-side fields are forced to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner              <= OwnerFetch;
      latchedAddress     <= '0;
      latchedWriteEnable <= 1'b0;
      latchedStrobe      <= '0;
      latchedWriteData   <= '0;
    end else if (dataGrant) begin
      owner              <= OwnerData;
      latchedAddress     <= dataAddress;
      latchedWriteEnable <= dataWriteEnable;
      latchedStrobe      <= dataWriteStrobe;
      latchedWriteData   <= dataWriteData;
    end else if (fetchGrant) begin
      owner              <= OwnerFetch;
      latchedAddress     <= fetchAddress;
      latchedWriteEnable <= 1'b0;
      latchedStrobe      <= '0;
      latchedWriteData   <= '0;
    end
  end

  // Streak of data grants taken while fetch was waiting. It saturates at the
  // limit rather than wrapping, and any grant with no fetch waiting (or any
  // fetch grant) starts the count over.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= '0;
    end else if (dataGrant) begin
      if (!fetchEligible) begin
        streak <= '0;
      end else if (streak != StreakLimit) begin
        streak <= streak + 1'b1;
      end
    end else if (fetchGrant) begin
      streak <= '0;
    end
  end

  // Cancel remembers a redirect that arrived while our fetch was in flight.
  // The bus transaction is still allowed to finish; only its reply is
  // dropped. Returning to idle takes priority so the flag never leaks into
  // the next transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      cancel <= 1'b0;
    end else if (leavingBusy) begin
      cancel <= 1'b0;
    end else if (fetchBusy && fetchFlush) begin
      cancel <= 1'b1;
    end
  end

  // Next-state and output decode. Every output defaults to zero and is
  // forced to zero during reset so nothing escapes while the block is being
  // cleared. Responses are passed straight through in the cycle they arrive.
  always_comb begin
    nextState          = state;
    fetchGrant         = 1'b0;
    dataGrant          = 1'b0;
    fetchResponseValid = 1'b0;
    fetchData          = '0;
    dataResponseValid  = 1'b0;
    dataReadData       = '0;
    memRequest         = 1'b0;
    memAddress         = '0;
    memWriteEnable     = 1'b0;
    memWriteStrobe     = '0;
    memWriteData       = '0;

    if (!reset) begin
      case (state)
        StIdle: begin
          dataGrant  = dataWins;
          fetchGrant = fetchWins;
          if (dataWins || fetchWins) begin
            nextState = StIssue;
          end
        end

        StIssue: begin
          memRequest     = 1'b1;
          memAddress     = latchedAddress;
          memWriteEnable = latchedWriteEnable;
          memWriteStrobe = latchedStrobe;
          memWriteData   = latchedWriteData;
          if (memReady) begin
            nextState = StWait;
          end
        end

        StWait: begin
          if (memResponseValid) begin
            nextState = StIdle;
            if (owner == OwnerData) begin
              dataResponseValid = 1'b1;
              dataReadData      = memReadData;
            end else if (!cancel && !fetchFlush) begin
              // A flush in the very cycle the reply lands also discards it.
              fetchResponseValid = 1'b1;
              fetchData          = memReadData;
            end
          end
        end

        default: begin
          nextState = StIdle;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // Only one requester can ever be granted in a cycle.
  assertSingleGrant: assert property (@(posedge clk) disable iff (reset)
    !(fetchGrant && dataGrant));

  // A response can only go to one side at a time.
  assertSingleResponse: assert property (@(posedge clk) disable iff (reset)
    !(fetchResponseValid && dataResponseValid));
`endif

endmodule
